ahb_uart_master: RTL and testbench
==================================

AHB_UART_MASTER -- requirements
Module: ahb_uart_master

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 4, setting the UART bit period to (PRESCALE+1)*16 HCLK cycles (80 cycles = 800 ns at 100 MHz).
REQ-002 The block SHALL have one clock and an asynchronous active-low reset: HCLK input, 1 bit, rising-edge system clock.
REQ-003 HRESETn  input  1  asynchronous active-low reset.
REQ-004 RX  input  1  UART serial in, idle high.
REQ-005 TX  output  1  UART serial out, idle high.
REQ-006 HADDR  output  32  AHB-Lite master address.
REQ-007 HTRANS  output  2  transfer type: IDLE=2'b00, NONSEQ=2'b10.
REQ-008 HSIZE  output  3  always 3'b010 (word).
REQ-009 HWRITE  output  1  1=write, 0=read.
REQ-010 HWDATA  output  32  write data.
REQ-011 HRDATA  input  32  read data.
REQ-012 HREADY  input  1  bus ready / transfer completion.

Function
REQ-013 The UART SHALL use 8N1 framing, LSB first, with a 16x oversampling tick every PRESCALE+1 HCLK cycles.
REQ-014 The receiver SHALL pass RX through a 2-flop synchronizer and detect the start bit on a falling edge.
REQ-015 The receiver SHALL confirm the start bit low at mid-bit (8 ticks), else return to idle.
REQ-016 The receiver SHALL sample each data bit at mid-bit (every 16 ticks).
REQ-017 The receiver SHALL drop a byte whose stop bit samples 0 (framing error); no byte-valid pulse.
REQ-018 The transmitter SHALL send start(0), 8 data bits, stop(1), each one bit period, and start a new byte only after the prior stop bit completes.
REQ-019 The control FSM SHALL have states IDLE, RX_ADDR, RX_DATA, AHB_ADDR, AHB_DATA, TX_DATA.
REQ-020 In IDLE, received byte 0xA3 SHALL select write and 0xA5 SHALL select read, both going to RX_ADDR; any other byte SHALL be discarded and the FSM stays in IDLE.
REQ-021 RX_ADDR SHALL collect 4 bytes LSB first into HADDR (byte0=A[7:0] ... byte3=A[31:24]), then go to RX_DATA for write or AHB_ADDR for read.
REQ-022 RX_DATA SHALL collect 4 bytes LSB first into the write-data register, then go to AHB_ADDR.
REQ-023 In AHB_ADDR the block SHALL drive HTRANS=NONSEQ with HADDR, HWRITE and HSIZE valid, held until a cycle with HREADY=1, then go to AHB_DATA.
REQ-024 In AHB_DATA, HTRANS SHALL be IDLE, HWDATA SHALL hold the write data stable, and the FSM SHALL wait for HREADY=1.
REQ-025 On HREADY=1 in AHB_DATA, a read SHALL capture HRDATA and go to TX_DATA; a write SHALL return to IDLE with no UART response.
REQ-026 TX_DATA SHALL transmit the 4 captured bytes LSB first (D[7:0] first), back-to-back, then return to IDLE.
REQ-027 Exactly one AHB transfer SHALL be issued per command; HTRANS SHALL be IDLE in every state except AHB_ADDR.
REQ-028 RX bytes arriving during AHB_ADDR, AHB_DATA or TX_DATA SHALL be discarded.

Reset
REQ-029 HRESETn low SHALL asynchronously force: FSM=IDLE, HTRANS=2'b00, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=3'b010, TX=1, UART RX/TX engines idle, byte counters=0.
REQ-030 Reset mid-frame or mid-transfer SHALL abort the command; after release the next 0xA3/0xA5 SHALL be decoded normally.

Verification
REQ-031 Send A3,04,00,00,00,01,00,00,00 -> one NONSEQ write, HADDR=0x00000004, HWRITE=1, HSIZE=010, HWDATA=0x00000001 in the data phase; TX stays high.
REQ-032 Send A5,18,00,00,00 with slave HRDATA=0x12345678 -> one NONSEQ read at 0x00000018; TX emits 78,56,34,12 with 800 ns bits.
REQ-033 Slave inserts 3 wait states (HREADY=0) in the data phase of a read -> HRDATA captured only on the HREADY=1 cycle; correct bytes returned.
REQ-034 Send 0x55, then A3 with address 0x0C and data 0x1 -> 0x55 ignored; single write to 0x0000000C with data 0x00000001.
REQ-035 Assert HRESETn after 2 address bytes of an A5 command -> no AHB transfer, TX=1; a subsequent full A5 command completes correctly.
REQ-036 Stop bit forced 0 on the command byte -> byte dropped, FSM stays IDLE, no bus activity.

Source files
------------

// File: rtl/ahb_uart_master.sv
// UART-to-AHB-Lite bridge: 8N1 command frames (0xA3 write / 0xA5 read) become single AHB
// word transfers; read data is returned over TX, LSB first.
`timescale 1ns/1ps
module ahb_uart_master #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        RX,
    output logic        TX,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY
);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [7:0] CmdWrite    = 8'hA3;
    localparam logic [7:0] CmdRead     = 8'hA5;

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {StIdle, StRxAddr, StRxData, StAhbAddr, StAhbData, StTxData} state_e;

    logic [15:0] ps_q;
    logic        tick_q;

    rx_state_e   rx_state_q;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [3:0]  rx_tcnt_q;
    logic [2:0]  rx_bit_q;
    logic [7:0]  rx_shreg_q;
    logic        rx_valid_q;

    logic        tx_busy_q, tx_q, tx_start_q;
    logic [8:0]  tx_frame_q;
    logic [3:0]  tx_bits_q, tx_tcnt_q;
    logic [7:0]  tx_byte_q;

    state_e      state_q;
    logic [2:0]  byte_cnt_q;
    logic [31:0] haddr_q, hwdata_q, rdata_q;
    logic [1:0]  htrans_q;
    logic        hwrite_q;

    assign TX     = tx_q;
    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HSIZE  = 3'b010;
    assign HWRITE = hwrite_q;
    assign HWDATA = hwdata_q;

    // 16x oversampling tick shared by receiver and transmitter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ps_q   <= '0;
            tick_q <= 1'b0;
        end else if (ps_q == 16'(PRESCALE)) begin
            ps_q   <= '0;
            tick_q <= 1'b1;
        end else begin
            ps_q   <= ps_q + 16'd1;
            tick_q <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_shreg_q <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_meta_q  <= RX;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_q <= 1'b0;
            case (rx_state_q)
                RxIdle: begin
                    if (!rx_sync_q && rx_prev_q) begin
                        rx_state_q <= RxStart;
                        rx_tcnt_q  <= '0;
                    end
                end
                RxStart: begin
                    if (tick_q) begin
                        if (rx_tcnt_q == 4'd7) begin
                            rx_tcnt_q  <= '0;
                            rx_bit_q   <= '0;
                            rx_state_q <= rx_sync_q ? RxIdle : RxData;
                        end else begin
                            rx_tcnt_q <= rx_tcnt_q + 4'd1;
                        end
                    end
                end
                RxData: begin
                    if (tick_q) begin
                        rx_tcnt_q <= rx_tcnt_q + 4'd1;
                        if (rx_tcnt_q == 4'd15) begin
                            rx_shreg_q <= {rx_sync_q, rx_shreg_q[7:1]};
                            rx_bit_q   <= rx_bit_q + 3'd1;
                            if (rx_bit_q == 3'd7) begin
                                rx_state_q <= RxStop;
                            end
                        end
                    end
                end
                RxStop: begin
                    if (tick_q) begin
                        rx_tcnt_q <= rx_tcnt_q + 4'd1;
                        if (rx_tcnt_q == 4'd15) begin
                            rx_state_q <= RxIdle;
                            rx_valid_q <= rx_sync_q;
                        end
                    end
                end
                default: rx_state_q <= RxIdle;
            endcase
        end
    end

    // tx_frame_q holds the bits still to be sent after the one currently on TX
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tx_busy_q  <= 1'b0;
            tx_q       <= 1'b1;
            tx_frame_q <= '1;
            tx_bits_q  <= '0;
            tx_tcnt_q  <= '0;
        end else if (!tx_busy_q) begin
            if (tx_start_q) begin
                tx_busy_q  <= 1'b1;
                tx_q       <= 1'b0;
                tx_frame_q <= {1'b1, tx_byte_q};
                tx_bits_q  <= 4'd9;
                tx_tcnt_q  <= '0;
            end
        end else if (tick_q) begin
            tx_tcnt_q <= tx_tcnt_q + 4'd1;
            if (tx_tcnt_q == 4'd15) begin
                if (tx_bits_q == 4'd0) begin
                    tx_busy_q <= 1'b0;
                    tx_q      <= 1'b1;
                end else begin
                    tx_q       <= tx_frame_q[0];
                    tx_frame_q <= {1'b1, tx_frame_q[8:1]};
                    tx_bits_q  <= tx_bits_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            haddr_q    <= '0;
            hwdata_q   <= '0;
            rdata_q    <= '0;
            htrans_q   <= TransIdle;
            hwrite_q   <= 1'b0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rx_valid_q && (rx_shreg_q == CmdWrite || rx_shreg_q == CmdRead)) begin
                        hwrite_q   <= (rx_shreg_q == CmdWrite);
                        byte_cnt_q <= '0;
                        state_q    <= StRxAddr;
                    end
                end
                StRxAddr: begin
                    if (rx_valid_q) begin
                        haddr_q    <= {rx_shreg_q, haddr_q[31:8]};
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        if (byte_cnt_q == 3'd3) begin
                            byte_cnt_q <= '0;
                            if (hwrite_q) begin
                                state_q <= StRxData;
                            end else begin
                                state_q  <= StAhbAddr;
                                htrans_q <= TransNonseq;
                            end
                        end
                    end
                end
                StRxData: begin
                    if (rx_valid_q) begin
                        hwdata_q   <= {rx_shreg_q, hwdata_q[31:8]};
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        if (byte_cnt_q == 3'd3) begin
                            byte_cnt_q <= '0;
                            state_q    <= StAhbAddr;
                            htrans_q   <= TransNonseq;
                        end
                    end
                end
                StAhbAddr: begin
                    if (HREADY) begin
                        htrans_q <= TransIdle;
                        state_q  <= StAhbData;
                    end
                end
                StAhbData: begin
                    if (HREADY) begin
                        if (hwrite_q) begin
                            state_q <= StIdle;
                        end else begin
                            rdata_q    <= HRDATA;
                            byte_cnt_q <= '0;
                            state_q    <= StTxData;
                        end
                    end
                end
                StTxData: begin
                    // tx_start_q guard covers the cycle before the engine raises busy
                    if (!tx_start_q && !tx_busy_q) begin
                        if (byte_cnt_q == 3'd4) begin
                            state_q <= StIdle;
                        end else begin
                            tx_start_q <= 1'b1;
                            tx_byte_q  <= rdata_q[7:0];
                            rdata_q    <= {8'h00, rdata_q[31:8]};
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_uart_master.sv
// Randomized bench for ahb_uart_master: UART command driver, AHB slave with wait states,
// TX byte decoder, and a transaction-level model of expected bus transfers and replies.
`timescale 1ns/1ps
module tb_ahb_uart_master;

    localparam int unsigned PRESCALE = 4;
    localparam int BIT_CYC = (PRESCALE + 1) * 16;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;

    always #5 HCLK = ~HCLK;

    ahb_uart_master #(.PRESCALE(PRESCALE)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .RX(RX), .TX(TX),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    int          n_checks = 0;
    int          n_errors = 0;
    xfer_t       exp_xfer[$];
    xfer_t       got_xfer[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];
    logic [31:0] rd_q[$];
    int          force_waits = -1;
    bit          tx_active = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    task automatic uart_send(input logic [7:0] b, input bit bad_stop = 1'b0);
        RX = 1'b0;
        cycles(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            cycles(BIT_CYC);
        end
        RX = bad_stop ? 1'b0 : 1'b1;
        cycles(BIT_CYC);
        RX = 1'b1;
        if (bad_stop) cycles(BIT_CYC);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) uart_send(w[8*i +: 8]);
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 8000; k++) begin
            if (got_xfer.size() >= exp_xfer.size() && got_tx.size() >= exp_tx.size()
                && !tx_active) break;
            @(posedge HCLK);
        end
        check("wait_done_in_budget", 32'(k < 8000), 32'd1);
        cycles(100);
    endtask

    // Model: a write command yields one write transfer and no UART reply
    task automatic cmd_write(input logic [31:0] a, input logic [31:0] d);
        xfer_t x;
        x.addr = a; x.wr = 1'b1; x.data = d;
        exp_xfer.push_back(x);
        uart_send(8'hA3);
        send_word(a);
        send_word(d);
        wait_done();
    endtask

    // Model: a read command yields one read transfer and the slave's word echoed LSB first
    task automatic cmd_read(input logic [31:0] a, input logic [31:0] rd);
        xfer_t x;
        x.addr = a; x.wr = 1'b0; x.data = '0;
        exp_xfer.push_back(x);
        rd_q.push_back(rd);
        for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
        uart_send(8'hA5);
        send_word(a);
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx"}, 32'(TX), 32'd1);
        check({tag, "_htrans"}, 32'(HTRANS), 32'd0);
        check({tag, "_haddr"}, HADDR, 32'd0);
        check({tag, "_hwdata"}, HWDATA, 32'd0);
        check({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
        check({tag, "_hsize"}, 32'(HSIZE), 32'd2);
    endtask

    // AHB slave: records each accepted transfer, inserts data-phase wait states
    initial begin
        xfer_t       sx;
        int          n;
        logic [31:0] rd;
        HREADY = 1'b1;
        HRDATA = 32'hDEAD_BEEF;
        forever begin
            @(posedge HCLK);
            if (HRESETn && HTRANS == 2'b10 && HREADY) begin
                sx.addr = HADDR;
                sx.wr   = HWRITE;
                sx.data = '0;
                check("hsize_addr_phase", 32'(HSIZE), 32'd2);
                n  = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 2));
                rd = (!HWRITE && rd_q.size() > 0) ? rd_q.pop_front() : $urandom;
                #1;
                HREADY = (n == 0);
                HRDATA = (n == 0) ? rd : ~rd;
                for (int k = 0; k < n; k++) begin
                    @(posedge HCLK);
                    check("htrans_wait_state", 32'(HTRANS), 32'd0);
                    #1;
                    if (k == n - 1) begin
                        HREADY = 1'b1;
                        HRDATA = rd;
                    end
                end
                @(posedge HCLK);
                check("htrans_data_phase", 32'(HTRANS), 32'd0);
                if (sx.wr) sx.data = HWDATA;
                got_xfer.push_back(sx);
                #1;
                HRDATA = $urandom;
            end
        end
    end

    // TX decoder: samples mid-bit relative to the start-bit falling edge
    initial begin
        logic [7:0] b;
        @(posedge HRESETn);
        forever begin
            @(negedge TX);
            tx_active = 1'b1;
            cycles(BIT_CYC / 2);
            check("tx_start_bit", 32'(TX), 32'd0);
            for (int i = 0; i < 8; i++) begin
                cycles(BIT_CYC);
                b[i] = TX;
            end
            cycles(BIT_CYC);
            check("tx_stop_bit", 32'(TX), 32'd1);
            got_tx.push_back(b);
            tx_active = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_before;
        #2 HRESETn = 1'b0;
        #1 check_reset_outputs("reset");
        cycles(5);
        HRESETn = 1'b1;
        cycles(20);

        cmd_write(32'h0000_0004, 32'h0000_0001);
        cmd_read(32'h0000_0018, 32'h1234_5678);

        force_waits = 3;
        cmd_read($urandom, $urandom);
        force_waits = -1;

        uart_send(8'h55);
        cmd_write(32'h0000_000C, 32'h0000_0001);

        // Abort a read command after two address bytes
        n_before = got_xfer.size();
        uart_send(8'hA5);
        uart_send(8'h20);
        uart_send(8'h00);
        HRESETn = 1'b0;
        #1 check_reset_outputs("midcmd_reset");
        cycles(5);
        HRESETn = 1'b1;
        cycles(200);
        check("no_xfer_after_abort", 32'(got_xfer.size()), 32'(n_before));
        cmd_read(32'h0000_0018, $urandom);

        // Command byte with a broken stop bit must be dropped
        n_before = got_xfer.size();
        uart_send(8'hA3, 1'b1);
        cycles(200);
        check("no_xfer_bad_stop", 32'(got_xfer.size()), 32'(n_before));
        check("htrans_idle_bad_stop", 32'(HTRANS), 32'd0);

        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 1) == 1) cmd_write($urandom, $urandom);
            else cmd_read($urandom, $urandom);
        end

        check("xfer_count", 32'(got_xfer.size()), 32'(exp_xfer.size()));
        for (int i = 0; i < exp_xfer.size() && i < got_xfer.size(); i++) begin
            check($sformatf("xfer%0d_addr", i), got_xfer[i].addr, exp_xfer[i].addr);
            check($sformatf("xfer%0d_write", i), 32'(got_xfer[i].wr), 32'(exp_xfer[i].wr));
            if (exp_xfer[i].wr) begin
                check($sformatf("xfer%0d_wdata", i), got_xfer[i].data, exp_xfer[i].data);
            end
        end
        check("tx_byte_count", 32'(got_tx.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++) begin
            check($sformatf("tx_byte%0d", i), 32'(got_tx[i]), 32'(exp_tx[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
